fir_mavg_pipe: RTL and testbench

Parametrised, pipelined moving-average FIR with power-of-two tap count, signed samples and round-half-up division by TAPS. It is the successor of the fixed 8-tap averager and adds four things: valid/ready handshaking with full-pipeline stall, warm-up suppression, synchronous clear, and a correct divide (shift by LOG2_TAPS, not a fixed 3). It sits between the sample source (ADC or capture front end) and downstream DSP consumers.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_adder_tree.sv | 75 +++++++
 rtl/fir_mavg_pipe.sv | 148 ++++++++++++++
 tb/tb_fir_mavg_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared types, width helper and rounding constant for the
//            moving-average FIR.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

   // Default sample width; the sample typedef is sized from it.
   localparam int c_DEF_WIDTH = 16;
   // Unit value that is shifted into the half-LSB rounding bias.
   localparam int c_ROUND_ONE = 1;

   typedef logic signed [c_DEF_WIDTH-1:0] sample_t;

   // Width of a full window sum: one growth bit per adder-tree level.
   function automatic int sum_width(input int width, input int log2_taps);
      return width + log2_taps;
   endfunction

   // Half of the divisor, added before the shift for round-half-up.
   function automatic int round_bias(input int log2_taps);
      return c_ROUND_ONE << (log2_taps - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : fir_adder_tree
// Purpose  : Registered binary adder tree of 2**LEVELS signed inputs with a
//            valid tag that travels alongside the data. Each level adds one
//            bit of sign extension.
// Revision : 1.0 - initial release
// ============================================================================
module fir_adder_tree #(
   parameter int W      = 16,
   parameter int LEVELS = 3
) (
   input  logic                   CLK,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   in_vld,
   input  logic [(W<<LEVELS)-1:0] in_flat,
   output logic                   out_vld,
   output logic [W+LEVELS-1:0]    out_sum
);

   localparam int c_N = 1 << LEVELS;

   logic [LEVELS-1:0] r_vld;

   // Valid tag shift register; clear kills every tag in flight.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_vld <= '0;
      end else if (clear) begin
         r_vld <= '0;
      end else if (en) begin
         r_vld[0] <= in_vld;
         for (int i = 1; i < LEVELS; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   assign out_vld = r_vld[LEVELS-1];

   for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
      localparam int c_NN = c_N >> lv;
      localparam int c_OW = W + lv;
      localparam int c_IW = c_OW - 1;

      logic [c_NN*c_OW-1:0]   r_flat;
      logic [2*c_NN*c_IW-1:0] w_src;

      if (lv == 1) begin : g_first
         assign w_src = in_flat;
      end else begin : g_next
         assign w_src = g_lvl[lv-1].r_flat;
      end

      // Pairwise sums of the previous level, each operand sign-extended.
      always_ff @(posedge CLK or negedge rst) begin
         if (!rst) begin
            r_flat <= '0;
         end else if (en) begin
            for (int k = 0; k < c_NN; k++) begin
               r_flat[k*c_OW +: c_OW] <= c_OW'($signed(w_src[(2*k)*c_IW +: c_IW]))
                                       + c_OW'($signed(w_src[(2*k+1)*c_IW +: c_IW]));
            end
         end
      end

      if (lv == LEVELS) begin : g_last
         assign out_sum = r_flat;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fir_mavg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fir_mavg_pipe
// Purpose  : Pipelined moving-average FIR over 2**LOG2_TAPS signed samples
//            with valid/ready flow control, whole-pipeline stall, warm-up
//            suppression, synchronous clear and round-half-up division.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mavg_pipe
   import fir_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int LOG2_TAPS       = 3,
   parameter int ROUND           = 1,
   parameter int SUPPRESS_WARMUP = 1
) (
   input  logic                                  CLK,
   input  logic                                  rst,
   input  logic                                  clear,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH-1:0]                      in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH-1:0]                      out_data,
   output logic [sum_width(WIDTH, LOG2_TAPS)-1:0] out_sum,
   output logic                                  primed
);

   localparam int c_TAPS = 1 << LOG2_TAPS;
   localparam int c_SW   = sum_width(WIDTH, LOG2_TAPS);
   localparam int c_FW   = LOG2_TAPS + 1;
   localparam int c_RND  = round_bias(LOG2_TAPS);

   localparam logic [c_FW-1:0] c_FILL_MAX  = c_FW'(c_TAPS);
   localparam logic [c_FW-1:0] c_FILL_LAST = c_FW'(c_TAPS - 1);

   logic [WIDTH-1:0]        r_win [c_TAPS];
   logic                    r_win_vld;
   logic [c_FW-1:0]         r_fill;
   logic                    r_out_valid;
   logic [WIDTH-1:0]        r_out_data;
   logic [c_SW-1:0]         r_out_sum;

   logic                    w_adv;
   logic                    w_accept;
   logic                    w_warm_ok;
   logic                    w_tag;
   logic [c_TAPS*WIDTH-1:0] w_win_flat;
   logic                    w_tree_vld;
   logic [c_SW-1:0]         w_tree_sum;
   logic [WIDTH-1:0]        w_avg;

   // The whole pipeline moves together; it freezes only while an output is
   // waiting on downstream.
   assign w_adv     = ~r_out_valid | out_ready;
   assign in_ready  = w_adv & ~clear;
   assign w_accept  = in_valid & in_ready;
   assign w_warm_ok = (SUPPRESS_WARMUP == 0) || (r_fill >= c_FILL_LAST);
   assign w_tag     = w_accept & w_warm_ok;

   // Sample window (pipeline stage 0) and its valid tag.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_TAPS; i++) begin
            r_win[i] <= '0;
         end
         r_win_vld <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < c_TAPS; i++) begin
            r_win[i] <= '0;
         end
         r_win_vld <= 1'b0;
      end else if (w_adv) begin
         if (w_accept) begin
            r_win[0] <= in_data;
            for (int i = 1; i < c_TAPS; i++) begin
               r_win[i] <= r_win[i-1];
            end
         end
         r_win_vld <= w_tag;
      end
   end

   // Saturating count of accepted samples since reset or clear.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_fill <= '0;
      end else if (clear) begin
         r_fill <= '0;
      end else if (w_accept && (r_fill != c_FILL_MAX)) begin
         r_fill <= r_fill + c_FW'(1);
      end
   end

   assign primed = (r_fill == c_FILL_MAX);

   for (genvar i = 0; i < c_TAPS; i++) begin : g_flat
      assign w_win_flat[i*WIDTH +: WIDTH] = r_win[i];
   end

   fir_adder_tree #(
      .W      (WIDTH),
      .LEVELS (LOG2_TAPS)
   ) u_tree (
      .CLK     (CLK),
      .rst     (rst),
      .en      (w_adv),
      .clear   (clear),
      .in_vld  (r_win_vld),
      .in_flat (w_win_flat),
      .out_vld (w_tree_vld),
      .out_sum (w_tree_sum)
   );

   // The divided result always fits WIDTH bits, so taking the slice after
   // the shift needs no saturation.
   if (ROUND != 0) begin : g_round
      logic [c_SW:0] w_biased;
      logic          w_unused_round;
      assign w_biased       = {w_tree_sum[c_SW-1], w_tree_sum} + (c_SW+1)'(c_RND);
      assign w_avg          = w_biased[LOG2_TAPS +: WIDTH];
      assign w_unused_round = ^{w_biased[c_SW], w_biased[LOG2_TAPS-1:0]};
   end else begin : g_trunc
      assign w_avg = w_tree_sum[LOG2_TAPS +: WIDTH];
   end

   // Output stage; holds everything while stalled.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sum   <= '0;
      end else if (clear) begin
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_tree_vld;
         r_out_data  <= w_avg;
         r_out_sum   <= w_tree_sum;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sum   = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_fir_mavg_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fir_mavg_pipe
// Purpose  : Self-checking bench for fir_mavg_pipe. A default instance and a
//            truncating, no-warm-up instance see the same accepted samples
//            and are compared with an arithmetic window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mavg_pipe;
   import fir_pkg::*;

   localparam int WIDTH = 16;
   localparam int L     = 3;
   localparam int TAPS  = 8;
   localparam int SW    = WIDTH + L;

   typedef struct {
      int data;
      int sum;
      int cyc;
   } exp_t;

   logic             CLK       = 1'b0;
   logic             rst       = 1'b0;
   logic             clear     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] in_data   = '0;

   logic             a_in_ready, a_out_valid, a_primed;
   logic [WIDTH-1:0] a_out_data;
   logic [SW-1:0]    a_out_sum;
   logic             b_in_valid, b_in_ready, b_out_valid, b_primed;
   logic [WIDTH-1:0] b_out_data;
   logic [SW-1:0]    b_out_sum;

   int   n_total = 0;
   int   n_bad   = 0;

   int   hist [TAPS];
   int   cnt = 0;
   exp_t qa[$];
   exp_t qb[$];
   int   cyc = 0;
   bit   lat_on = 1'b1;
   bit   prev_stall = 1'b0;
   int   prev_data, prev_sum;
   int   hs_a = 0, n125 = 0;
   int   last_a = 0, last_a_sum = 0, last_b = 0;

   always #5 CLK = ~CLK;

   // B sees exactly the samples A accepts.
   assign b_in_valid = in_valid & a_in_ready;

   fir_mavg_pipe u_dut_a (
      .CLK       (CLK),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .in_data   (in_data),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_data  (a_out_data),
      .out_sum   (a_out_sum),
      .primed    (a_primed)
   );

   fir_mavg_pipe #(
      .WIDTH           (WIDTH),
      .LOG2_TAPS       (L),
      .ROUND           (0),
      .SUPPRESS_WARMUP (0)
   ) u_dut_b (
      .CLK       (CLK),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (in_data),
      .out_valid (b_out_valid),
      .out_ready (1'b1),
      .out_data  (b_out_data),
      .out_sum   (b_out_sum),
      .primed    (b_primed)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int sdata(input logic [WIDTH-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int ssum(input logic [SW-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      cnt = 0;
      qa.delete();
      qb.delete();
   endfunction

   // Window of the last TAPS accepted samples, zero-filled after reset/clear.
   function automatic void model_accept(input int v);
      exp_t e;
      int   s;
      for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = v;
      if (cnt < TAPS) cnt++;
      s = 0;
      for (int i = 0; i < TAPS; i++) s += hist[i];
      e.sum = s;
      e.cyc = cyc;
      e.data = floor_div(s + TAPS / 2, TAPS);
      if (cnt >= TAPS) qa.push_back(e);
      e.data = floor_div(s, TAPS);
      qb.push_back(e);
   endfunction

   // Monitor: observe at the falling edge, check outputs, advance model.
   always @(negedge CLK) begin
      if (!rst) begin
         chk("rst_valid_a", int'(a_out_valid), 0);
         chk("rst_primed_a", int'(a_primed), 0);
         chk("rst_valid_b", int'(b_out_valid), 0);
         model_flush();
         prev_stall = 1'b0;
      end else begin
         cyc++;
         chk("primed_a", int'(a_primed), int'(cnt >= TAPS));
         chk("primed_b", int'(b_primed), int'(cnt >= TAPS));
         chk("ready_b", int'(b_in_ready), int'(!clear));
         if (prev_stall) begin
            chk("hold_valid", int'(a_out_valid), 1);
            chk("hold_data", sdata(a_out_data), prev_data);
            chk("hold_sum", ssum(a_out_sum), prev_sum);
         end
         if (a_out_valid) begin
            if (qa.size() == 0) begin
               chk("spurious_a", int'(a_out_valid), 0);
            end else begin
               chk("data_a", sdata(a_out_data), qa[0].data);
               chk("sum_a", ssum(a_out_sum), qa[0].sum);
               if (lat_on && !prev_stall) chk("lat_a", cyc - qa[0].cyc, L + 2);
               if (out_ready) begin
                  hs_a++;
                  last_a     = sdata(a_out_data);
                  last_a_sum = ssum(a_out_sum);
                  if (last_a == 125) n125++;
                  void'(qa.pop_front());
               end
            end
            if (!out_ready) chk("stall_ready", int'(a_in_ready), 0);
         end
         if (b_out_valid) begin
            if (qb.size() == 0) begin
               chk("spurious_b", int'(b_out_valid), 0);
            end else begin
               chk("data_b", sdata(b_out_data), qb[0].data);
               chk("sum_b", ssum(b_out_sum), qb[0].sum);
               chk("lat_b", cyc - qb[0].cyc, L + 2);
               last_b = sdata(b_out_data);
               void'(qb.pop_front());
            end
         end
         if (clear) begin
            chk("clear_ready", int'(a_in_ready), 0);
            model_flush();
         end else if (in_valid && a_in_ready) begin
            model_accept(sdata(in_data));
         end
         prev_stall = a_out_valid && !out_ready && !clear;
         prev_data  = sdata(a_out_data);
         prev_sum   = ssum(a_out_sum);
      end
   end

   task automatic push(input int v);
      bit ok;
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = sample_t'(v);
      do begin
         @(negedge CLK);
         ok = a_in_ready && !clear;
         @(posedge CLK);
         #1;
         guard++;
      end while (!ok && guard < 50);
      if (!ok) chk("push_timeout", int'(ok), 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int rtab [4][3] = '{'{-20, -2, -3}, '{-8, -1, -1}, '{12, 2, 1}, '{11, 1, 1}};

   initial begin : stim
      int h0, c0;
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      rst = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_out_valid", int'(a_out_valid), 0);
      chk("reset_out_data", sdata(a_out_data), 0);
      chk("reset_out_sum", ssum(a_out_sum), 0);
      chk("reset_primed", int'(a_primed), 0);
      rst = 1'b1;

      // 1: eight back-to-back 8s
      for (int i = 0; i < 8; i++) push(8);
      chk("t1_no_early", hs_a, 0);
      chk("t1_primed", int'(a_primed), 1);
      idle(6);
      chk("t1_count", hs_a, 1);
      chk("t1_data", last_a, 8);
      chk("t1_sum", last_a_sum, 64);

      // 2: impulse response
      for (int i = 0; i < 8; i++) push(0);
      c0 = n125;
      push(1000);
      for (int i = 0; i < 8; i++) push(0);
      idle(7);
      chk("t2_count_125", n125 - c0, 8);
      chk("t2_tail", last_a, 0);

      // 3: rounding against truncation
      for (int r = 0; r < 4; r++) begin
         push(rtab[r][0]);
         for (int i = 0; i < 7; i++) push(0);
         idle(7);
         chk("t3_round", last_a, rtab[r][1]);
         chk("t3_trunc", last_b, rtab[r][2]);
         chk("t3_sum", last_a_sum, rtab[r][0]);
      end

      // 4: full scale both polarities
      for (int i = 0; i < 8; i++) push(32767);
      idle(7);
      chk("t4_max", last_a, 32767);
      chk("t4_max_sum", last_a_sum, 262136);
      chk("t4_max_b", last_b, 32767);
      for (int i = 0; i < 8; i++) push(-32768);
      idle(7);
      chk("t4_min", last_a, -32768);
      chk("t4_min_sum", last_a_sum, -262144);
      chk("t4_min_b", last_b, -32768);

      // 5: backpressure with random data
      lat_on = 1'b0;
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'b1;
         in_data   = WIDTH'($urandom);
         out_ready = (i < 10) ? 1'b0 : 1'($urandom_range(0, 1));
         if (i == 9) begin
            @(negedge CLK);
            chk("t5_stalled_ready", int'(a_in_ready), 0);
            chk("t5_stalled_valid", int'(a_out_valid), 1);
         end
         @(posedge CLK);
         #1;
      end
      out_ready = 1'b1;
      idle(15);
      chk("t5_drain_a", qa.size(), 0);
      chk("t5_drain_b", qb.size(), 0);
      lat_on = 1'b1;

      // 6a: clear together with a valid sample
      for (int i = 0; i < 12; i++) push(int'($urandom_range(0, 2000)) - 1000);
      in_valid = 1'b1;
      in_data  = sample_t'(777);
      clear    = 1'b1;
      @(posedge CLK);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t6_clr_valid", int'(a_out_valid), 0);
      chk("t6_clr_primed", int'(a_primed), 0);
      h0 = hs_a;
      push(8);
      idle(6);
      chk("t6_b_first", last_b, 1);
      for (int i = 0; i < 6; i++) push(8);
      idle(8);
      chk("t6_b_seventh", last_b, 7);
      chk("t6_none_7", hs_a - h0, 0);
      push(8);
      idle(7);
      chk("t6_one_8", hs_a - h0, 1);
      chk("t6_data", last_a, 8);

      // 6b: reset pulse mid-stream
      for (int i = 0; i < 12; i++) push(int'($urandom_range(0, 2000)) - 1000);
      rst = 1'b0;
      @(negedge CLK);
      chk("t6_rst_valid", int'(a_out_valid), 0);
      chk("t6_rst_primed", int'(a_primed), 0);
      @(posedge CLK);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      h0 = hs_a;
      for (int i = 0; i < 7; i++) push(16);
      idle(8);
      chk("t6_rst_none_7", hs_a - h0, 0);
      push(16);
      idle(7);
      chk("t6_rst_one_8", hs_a - h0, 1);
      chk("t6_rst_data", last_a, 16);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
